// File: rtl/parallax_layer_sequencer.sv
// parallax_layer_sequencer
// Per-layer horizontal scroll state for the 4-layer parallax renderer.
// Once per frame each layer's sub-column counter / LFSR pair is advanced by
// its speed.  Once per scanline the four layers' reload values and skyline
// cutoffs are streamed, one layer per cycle, over a shared load bus.
// Frame advances always win over line loads when both are waiting, so a
// load that follows an advance carries the advanced state.

module parallax_layer_sequencer #(
    parameter logic [8:0] SEED       = 9'h1FF,
    parameter int         HORIZON    = 128,
    parameter int         LAYER_STEP = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        line_start,
    input  logic [9:0]  vcount,
    input  logic [11:0] speed,
    input  logic        pause,
    output logic        ld_valid,
    output logic [1:0]  ld_layer,
    output logic [8:0]  ld_lfsr,
    output logic [2:0]  ld_count,
    output logic [4:0]  ld_cutoff,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FADV  = 2'd1,
        ST_LLOAD = 2'd2
    } state_t;

    localparam logic [11:0] HORIZON_W    = 12'(HORIZON);
    localparam logic [11:0] LAYER_STEP_W = 12'(LAYER_STEP);

    // One step of the 9-bit scroll LFSR (taps 9 and 5).
    function automatic logic [8:0] lfsr_step(input logic [8:0] v);
        lfsr_step = {v[7:0], v[8] ^ v[4]};
    endfunction

    // 3-bit speed field of layer k.
    function automatic logic [2:0] speed_of(input logic [11:0] s, input logic [1:0] k);
        case (k)
            2'd0:    speed_of = s[2:0];
            2'd1:    speed_of = s[5:3];
            2'd2:    speed_of = s[8:6];
            2'd3:    speed_of = s[11:9];
            default: speed_of = 3'd0;
        endcase
    endfunction

    // Skyline cutoff: 0 above the layer's horizon, then one row of 16
    // scanlines per step, saturating at 16.
    function automatic logic [4:0] cutoff_of(input logic [9:0] vl, input logic [1:0] k);
        logic [11:0] d;
        logic [7:0]  rows;
        d    = {2'b00, vl} + (LAYER_STEP_W * {10'd0, k}) - HORIZON_W;
        rows = {1'b0, d[10:4]} + 8'd1;
        if (d[11]) begin
            cutoff_of = 5'd0;
        end else if (rows > 8'd16) begin
            cutoff_of = 5'd16;
        end else begin
            cutoff_of = rows[4:0];
        end
    endfunction

    // Sequencer state.
    state_t      state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic        pf_q, pf_d;
    logic        pl_q, pl_d;
    logic [9:0]  vlat_q, vlat_d;

    // Per-layer scroll state.
    logic [8:0]  lfsr_q [4];
    logic [8:0]  lfsr_d [4];
    logic [2:0]  cnt_q  [4];
    logic [2:0]  cnt_d  [4];

    // Registered load bus and busy flag.
    logic        ld_valid_q, ld_valid_d;
    logic [1:0]  ld_layer_q, ld_layer_d;
    logic [8:0]  ld_lfsr_q,  ld_lfsr_d;
    logic [2:0]  ld_count_q, ld_count_d;
    logic [4:0]  ld_cutoff_q, ld_cutoff_d;
    logic        busy_q, busy_d;

    // Combinational helpers.
    logic        frame_req;
    logic        line_req;
    logic        dispatch;
    logic [3:0]  adv_sum;

    // Next-state logic: pending flags, layer advance, and dispatch decision.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        pf_d      = pf_q | frame_start;
        pl_d      = pl_q | line_start;
        vlat_d    = vlat_q;
        lfsr_d    = lfsr_q;
        cnt_d     = cnt_q;
        adv_sum   = 4'd0;
        frame_req = pf_q | frame_start;
        line_req  = pl_q | line_start;

        // A new burst may be chosen when idle or on the last cycle of a burst.
        if (state_q == ST_IDLE) begin
            dispatch = 1'b1;
        end else if (k_q == 2'd3) begin
            dispatch = 1'b1;
        end else begin
            dispatch = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                k_d = 2'd0;
            end
            ST_FADV: begin
                // Pause still spends the four cycles but freezes the layer.
                if (!pause) begin
                    adv_sum      = {1'b0, cnt_q[k_q]} + {1'b0, speed_of(speed, k_q)};
                    cnt_d[k_q]   = adv_sum[2:0];
                    if (adv_sum[3]) begin
                        lfsr_d[k_q] = lfsr_step(lfsr_q[k_q]);
                    end else begin
                        lfsr_d[k_q] = lfsr_q[k_q];
                    end
                end else begin
                    cnt_d[k_q]  = cnt_q[k_q];
                    lfsr_d[k_q] = lfsr_q[k_q];
                end
                k_d = k_q + 2'd1;
            end
            ST_LLOAD: begin
                k_d = k_q + 2'd1;
            end
            default: begin
                state_d = ST_IDLE;
                k_d     = 2'd0;
            end
        endcase

        if (dispatch) begin
            if (frame_req) begin
                state_d = ST_FADV;
                k_d     = 2'd0;
                pf_d    = 1'b0;
            end else if (line_req) begin
                state_d = ST_LLOAD;
                k_d     = 2'd0;
                pl_d    = 1'b0;
                vlat_d  = vcount;
            end else begin
                state_d = ST_IDLE;
                k_d     = 2'd0;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Load bus: driven from the upcoming state so each load appears in the
    // same cycle as its LLOAD step; holds its last value between bursts.
    always_comb begin
        ld_valid_d  = 1'b0;
        ld_layer_d  = ld_layer_q;
        ld_lfsr_d   = ld_lfsr_q;
        ld_count_d  = ld_count_q;
        ld_cutoff_d = ld_cutoff_q;
        busy_d      = (state_d != ST_IDLE);
        if (state_d == ST_LLOAD) begin
            ld_valid_d  = 1'b1;
            ld_layer_d  = k_d;
            ld_lfsr_d   = lfsr_q[k_d];
            ld_count_d  = cnt_q[k_d];
            ld_cutoff_d = cutoff_of(vlat_d, k_d);
        end else begin
            ld_valid_d  = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_q         <= 2'd0;
            pf_q        <= 1'b0;
            pl_q        <= 1'b0;
            vlat_q      <= 10'd0;
            for (int i = 0; i < 4; i++) begin
                lfsr_q[i] <= SEED;
                cnt_q[i]  <= 3'd7;
            end
            ld_valid_q  <= 1'b0;
            ld_layer_q  <= 2'd0;
            ld_lfsr_q   <= 9'd0;
            ld_count_q  <= 3'd0;
            ld_cutoff_q <= 5'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            pf_q        <= pf_d;
            pl_q        <= pl_d;
            vlat_q      <= vlat_d;
            for (int i = 0; i < 4; i++) begin
                lfsr_q[i] <= lfsr_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            ld_valid_q  <= ld_valid_d;
            ld_layer_q  <= ld_layer_d;
            ld_lfsr_q   <= ld_lfsr_d;
            ld_count_q  <= ld_count_d;
            ld_cutoff_q <= ld_cutoff_d;
            busy_q      <= busy_d;
        end
    end

    assign ld_valid  = ld_valid_q;
    assign ld_layer  = ld_layer_q;
    assign ld_lfsr   = ld_lfsr_q;
    assign ld_count  = ld_count_q;
    assign ld_cutoff = ld_cutoff_q;
    assign busy      = busy_q;

endmodule
